// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the execute stage and the alu.
//   master (execute stage): drives operation, a, b; receives out, flag
//   slave  (alu)          : receives operation, a, b; drives out, flag
// operation encoding: 00 add, 01 sub, 10 and, 11 xor.
interface alu_if #(
  parameter int WIDTH = 64
);
  logic [1:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             flag;

  modport master (output operation, output a, output b, input out, input flag);
  modport slave  (input operation, input a, input b, output out, output flag);
endinterface

// File: rtl/alu.sv
// alu: two's-complement ALU for the Y86-64 execute stage (OPq, address
// and stack-pointer arithmetic).
//   clk  : rising-edge clock; inputs sampled on every edge
//   rst  : asynchronous active-high reset, clears out/flag
//   bus  : alu_if.slave -- operation/a/b in, out/flag out
// out and flag are registered together, one-cycle latency, one result per
// cycle. flag is signed overflow for add/sub and 0 for and/xor.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic   clk,
  input  logic   rst,
  alu_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             flag;
  } res_t;

  op_e              op;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  res_t             res_d;
  res_t             res_q;

  assign op     = op_e'(bus.operation);
  assign is_sub = (op == OP_SUB);

  // Subtract shares the adder: a + ~b + 1. Carry-out is dropped.
  assign b_eff = is_sub ? ~bus.b : bus.b;
  assign sum   = bus.a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

  // Overflow when both adder inputs agree in sign and the result does not.
  // Using b_eff folds the sub rule (a, b signs differ) into the add rule.
  assign ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
               (sum[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    res_d = '0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        res_d.out  = sum;
        res_d.flag = ovf;
      end
      OP_AND: res_d.out = bus.a & bus.b;
      OP_XOR: res_d.out = bus.a ^ bus.b;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign bus.out  = res_q.out;
  assign bus.flag = res_q.flag;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  localparam int W = 64;

  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_flag;
    string        name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  vec_t vecs[$];

  alu_if #(.WIDTH(W)) bus ();
  alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk_out(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s out: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_flag(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s flag: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic ef, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_out = eo; v.exp_flag = ef; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.operation = op;
    bus.a = a;
    bus.b = b;
  endtask

  initial begin
    drive(2'b00, '0, '0);

    // Hand-computed vectors, applied back-to-back one per cycle.
    add_vec(2'b00, 64'd10,   64'd20,   64'd30,   1'b0, "add_10_20");
    add_vec(2'b00, MAXP,     64'd1,    MINN,     1'b1, "add_maxp_1");
    add_vec(2'b00, ONES,     64'd1,    64'd0,    1'b0, "add_m1_1");
    add_vec(2'b01, 64'd8,    64'd8,    64'd0,    1'b0, "sub_8_8");
    add_vec(2'b01, 64'd5,    64'd9,    64'hFFFF_FFFF_FFFF_FFFC, 1'b0, "sub_5_9");
    add_vec(2'b01, MINN,     64'd1,    MAXP,     1'b1, "sub_minn_1");
    add_vec(2'b01, 64'd0,    MINN,     MINN,     1'b1, "sub_0_minn");
    add_vec(2'b10, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, "and_f0f0");
    add_vec(2'b11, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, "xor_f0f0");
    add_vec(2'b11, 64'hDEAD, 64'hDEAD, 64'd0,    1'b0, "xor_self");
    add_vec(2'b00, 64'h100,  64'd8,    64'h108,  1'b0, "stk_push");
    add_vec(2'b01, 64'h100,  64'd8,    64'hF8,   1'b0, "stk_pop");
    add_vec(2'b00, MINN,     MINN,     64'd0,    1'b1, "add_neg_ovf");
    add_vec(2'b01, MAXP,     ONES,     MINN,     1'b1, "sub_maxp_m1");
    add_vec(2'b10, MINN,     ONES,     MINN,     1'b0, "and_msb");
    add_vec(2'b11, MAXP,     ONES,     MINN,     1'b0, "xor_msb");
    add_vec(2'b00, 64'd3,    64'd4,    64'd7,    1'b0, "pipe_add");
    add_vec(2'b01, 64'd3,    64'd4,    ONES,     1'b0, "pipe_sub");
    add_vec(2'b10, 64'hC,    64'hA,    64'h8,    1'b0, "pipe_and");
    add_vec(2'b11, 64'hC,    64'hA,    64'h6,    1'b0, "pipe_xor");

    // Reset state.
    #1;
    chk_out("reset_init", bus.out, '0);
    chk_flag("reset_init", bus.flag, 1'b0);
    @(posedge clk); #1;
    chk_out("reset_hold", bus.out, '0);

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      // Output must not react to new inputs before the sampling edge.
      if (i != 0) begin
        #1;
        chk_out({vecs[i].name, "_pre"}, bus.out, vecs[i-1].exp_out);
      end
      @(posedge clk); #1;
      chk_out(vecs[i].name, bus.out, vecs[i].exp_out);
      chk_flag(vecs[i].name, bus.flag, vecs[i].exp_flag);
    end

    // Mid-cycle async reset with a nonzero result and flag=1 registered.
    @(negedge clk);
    drive(2'b00, MAXP, 64'd1);
    @(posedge clk); #1;
    chk_out("pre_rst", bus.out, MINN);
    chk_flag("pre_rst", bus.flag, 1'b1);
    @(negedge clk);
    drive(2'b00, 64'd1, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", bus.out, '0);
    chk_flag("async_rst", bus.flag, 1'b0);
    @(posedge clk); #1;
    chk_out("rst_discard", bus.out, '0);
    chk_flag("rst_discard", bus.flag, 1'b0);
    @(posedge clk); #1;
    chk_out("rst_hold2", bus.out, '0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 64'd5, 64'd6);
    #1;
    chk_out("rst_release_pre", bus.out, '0);
    @(posedge clk); #1;
    chk_out("rst_release", bus.out, 64'd11);
    chk_flag("rst_release", bus.flag, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
